// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data requesters onto one single-port memory, data has fixed priority.
// Latency: req in IDLE -> m_req next cycle -> ready pulse one cycle after m_ack (min 2 cycles).
// Backpressure: one outstanding transaction; a requester holds req (stall=1) until its ready pulse.
module mem_arbiter #(
   parameter int DW = 32,
   parameter int AW = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_req,
   input  logic [AW-1:0]   i_addr,
   output logic [DW-1:0]   i_rdata,
   output logic            i_ready,
   input  logic            d_req,
   input  logic            d_wr,
   input  logic [AW-1:0]   d_addr,
   input  logic [DW-1:0]   d_wdata,
   input  logic [DW/8-1:0] d_wstrb,
   output logic [DW-1:0]   d_rdata,
   output logic            d_ready,
   output logic            m_req,
   output logic            m_wr,
   output logic [AW-1:0]   m_addr,
   output logic [DW-1:0]   m_wdata,
   output logic [DW/8-1:0] m_wstrb,
   input  logic [DW-1:0]   m_rdata,
   input  logic            m_ack,
   output logic            stall,
   output logic [31:0]     i_cnt,
   output logic [31:0]     d_cnt
);

   typedef enum logic [2:0] {IDLE, IBUSY, DBUSY, IRESP, DRESP} stateT;

   stateT             state, nextState;
   logic [AW-1:0]     cmdAddr;
   logic              cmdWr;
   logic [DW-1:0]     cmdWdata;
   logic [DW/8-1:0]   cmdWstrb;
   logic [DW-1:0]     iRdata, dRdata;
   logic [31:0]       iCnt, dCnt;

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= nextState;
   end

   always_comb begin
      nextState = state;
      unique case (state)
         IDLE: begin
            if (d_req)      nextState = DBUSY;
            else if (i_req) nextState = IBUSY;
         end
         IBUSY:   if (m_ack) nextState = IRESP;
         DBUSY:   if (m_ack) nextState = DRESP;
         IRESP:   nextState = IDLE;
         DRESP:   nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Command is frozen on BUSY entry so requester inputs may wander while the memory works.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cmdAddr  <= '0;
         cmdWr    <= 1'b0;
         cmdWdata <= '0;
         cmdWstrb <= '0;
         iRdata   <= '0;
         dRdata   <= '0;
         iCnt     <= '0;
         dCnt     <= '0;
      end else begin
         if (state == IDLE) begin
            if (d_req) begin
               cmdAddr  <= d_addr;
               cmdWr    <= d_wr;
               cmdWdata <= d_wdata;
               cmdWstrb <= d_wstrb;
            end else if (i_req) begin
               cmdAddr  <= i_addr;
               cmdWr    <= 1'b0;
               cmdWdata <= '0;
               cmdWstrb <= '0;
            end
         end
         if (state == IBUSY && m_ack)           iRdata <= m_rdata;
         if (state == DBUSY && m_ack && !cmdWr) dRdata <= m_rdata;
         if (state == IRESP) iCnt <= iCnt + 32'd1;
         if (state == DRESP) dCnt <= dCnt + 32'd1;
      end
   end

   assign m_req   = (state == IBUSY) || (state == DBUSY);
   assign m_wr    = cmdWr;
   assign m_addr  = cmdAddr;
   assign m_wdata = cmdWdata;
   assign m_wstrb = cmdWstrb;

   assign i_ready = (state == IRESP);
   assign d_ready = (state == DRESP);
   assign i_rdata = iRdata;
   assign d_rdata = dRdata;
   assign i_cnt   = iCnt;
   assign d_cnt   = dCnt;

   assign stall = (d_req & ~d_ready) | (i_req & ~i_ready);

endmodule
